// File: rtl/crypto_stub_pkg.sv
// Shared constants, register offsets, FSM encoding and keyvault port types for the crypto AHB stub.
package crypto_stub_pkg;

  localparam logic [11:0] ADDR_NAME0    = 12'h000;
  localparam logic [11:0] ADDR_NAME1    = 12'h004;
  localparam logic [11:0] ADDR_VERSION0 = 12'h008;
  localparam logic [11:0] ADDR_VERSION1 = 12'h00C;
  localparam logic [11:0] ADDR_CTRL     = 12'h010;
  localparam logic [11:0] ADDR_STATUS   = 12'h018;
  localparam logic [11:0] ADDR_INTR_STS = 12'h01C;
  localparam logic [11:0] ADDR_INTR_EN  = 12'h020;
  localparam logic [11:0] ADDR_SCRATCH  = 12'h100;

  localparam logic [31:0] NAME0_VAL    = 32'h5354_5542;
  localparam logic [31:0] NAME1_VAL    = 32'h4352_5950;
  localparam logic [31:0] VERSION0_VAL = 32'h0000_0001;
  localparam logic [31:0] VERSION1_VAL = 32'h0000_0000;

  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_VALID_BIT = 1;
  localparam int INTR_NOTIF_BIT   = 0;
  localparam int INTR_ERROR_BIT   = 1;
  localparam int CTRL_ZEROIZE_BIT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } stub_state_e;

  typedef struct packed {
    logic       read_entry_en;
    logic [4:0] read_entry;
    logic [3:0] read_offset;
  } kv_read_t;

  typedef struct packed {
    logic        error;
    logic        last;
    logic [31:0] read_data;
  } kv_rd_resp_t;

  typedef struct packed {
    logic        write_en;
    logic [4:0]  write_entry;
    logic [3:0]  write_offset;
    logic [31:0] write_data;
    logic [5:0]  write_dest_valid;
  } kv_write_t;

  typedef struct packed {
    logic error;
  } kv_wr_resp_t;

  typedef struct packed {
    logic [383:0] pcr_hash;
    logic [383:0] pcr_signing_privkey;
  } pcr_signing_t;

endpackage

// File: rtl/crypto_stub_ahb_sif.sv
// AHB-lite slave front end: captures the address phase, checks size/alignment and
// sequences the two-cycle ERROR response around a simple req/we/addr/wdata/rdata/err port.
module crypto_stub_ahb_sif #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hsel_i,
  input  logic                      hwrite_i,
  input  logic                      hready_i,
  input  logic [1:0]                htrans_i,
  input  logic [2:0]                hsize_i,
  output logic                      hresp_o,
  output logic                      hreadyout_o,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      req_o,
  output logic                      we_o,
  output logic [11:0]               addr_o,
  output logic [31:0]               wdata_o,
  input  logic [31:0]               rdata_i,
  input  logic                      err_i
);

  logic        accept;
  logic        dph_vld_q;
  logic        dph_we_q;
  logic        dph_fmt_ok_q;
  logic [11:0] dph_addr_q;
  logic        err2_q;
  logic        dph_err;
  logic        unused_sif;

  assign accept = hsel_i & hready_i & htrans_i[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dph_vld_q    <= 1'b0;
      dph_we_q     <= 1'b0;
      dph_fmt_ok_q <= 1'b0;
      dph_addr_q   <= '0;
      err2_q       <= 1'b0;
    end else begin
      dph_vld_q <= accept;
      if (accept) begin
        dph_we_q     <= hwrite_i;
        dph_addr_q   <= haddr_i[11:0];
        dph_fmt_ok_q <= (hsize_i == 3'b010) && (haddr_i[1:0] == 2'b00);
      end
      err2_q <= dph_err;
    end
  end

  // A bad size/alignment never reaches the register logic, so it cannot have side effects.
  assign dph_err     = dph_vld_q & (~dph_fmt_ok_q | err_i);
  assign req_o       = dph_vld_q & dph_fmt_ok_q;
  assign we_o        = dph_we_q;
  assign addr_o      = dph_addr_q;
  assign wdata_o     = hwdata_i[31:0];
  assign hreadyout_o = ~dph_err;
  assign hresp_o     = dph_err | err2_q;
  assign hrdata_o    = (req_o & ~dph_we_q & ~err_i) ? rdata_i : '0;

  assign unused_sif = ^{haddr_i, htrans_i[0]};

endmodule

// File: rtl/crypto_ahb_stub.sv
// Crypto engine stand-in: register map, busy/ready command model, scratch array, interrupts.
// CRYPTO_STUB_BUSY_MODEL_EN enables the BUSY_CYCLES latency counter; otherwise BUSY lasts one clock.
module crypto_ahb_stub
  import crypto_stub_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 64,
  parameter int BUSY_CYCLES    = 16,
  parameter int NUM_KV_RD      = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cptra_pwrgood,
  input  logic [AHB_ADDR_WIDTH-1:0]     haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0]     hwdata_i,
  input  logic                          hsel_i,
  input  logic                          hwrite_i,
  input  logic                          hready_i,
  input  logic [1:0]                    htrans_i,
  input  logic [2:0]                    hsize_i,
  output logic                          hresp_o,
  output logic                          hreadyout_o,
  output logic [AHB_DATA_WIDTH-1:0]     hrdata_o,
  output kv_read_t [NUM_KV_RD-1:0]      kv_read,
  output kv_write_t                     kv_write,
  input  kv_rd_resp_t [NUM_KV_RD-1:0]   kv_rd_resp,
  input  kv_wr_resp_t                   kv_wr_resp,
  input  pcr_signing_t                  pcr_signing_data,
  output logic                          error_intr,
  output logic                          notif_intr,
  input  logic                          debugUnlock_or_scan_mode_switch
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  if (AHB_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("crypto_ahb_stub: AHB_DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 1 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("crypto_ahb_stub: NUM_REGS must be a power of 2 in 1..256");
  end
  if (BUSY_CYCLES < 1) begin : g_bad_busy_cycles
    $error("crypto_ahb_stub: BUSY_CYCLES must be >= 1");
  end

  logic              req, we, reg_err;
  logic [11:0]       addr, scr_off;
  logic [31:0]       wdata, rdata;
  logic              scr_hit, wr, scr_wr, ctrl_wr, zeroize, start, busy_done;
  logic [IDX_W-1:0]  scr_idx;
  logic [1:0]        set_mask, w1c_mask;
  stub_state_e       state_q, state_d;
  logic              valid_q, valid_d;
  logic [1:0]        sts_q, sts_d, en_q, en_d;
  logic              notif_intr_q, error_intr_q;
  logic [31:0]       scratch_q [NUM_REGS];
  logic              unused_inputs;

  crypto_stub_ahb_sif #(
    .AHB_ADDR_WIDTH (AHB_ADDR_WIDTH),
    .AHB_DATA_WIDTH (AHB_DATA_WIDTH)
  ) u_sif (
    .clk         (clk),
    .reset_n     (reset_n),
    .haddr_i     (haddr_i),
    .hwdata_i    (hwdata_i),
    .hsel_i      (hsel_i),
    .hwrite_i    (hwrite_i),
    .hready_i    (hready_i),
    .htrans_i    (htrans_i),
    .hsize_i     (hsize_i),
    .hresp_o     (hresp_o),
    .hreadyout_o (hreadyout_o),
    .hrdata_o    (hrdata_o),
    .req_o       (req),
    .we_o        (we),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .rdata_i     (rdata),
    .err_i       (reg_err)
  );

  assign scr_off = addr - ADDR_SCRATCH;
  assign scr_hit = (addr >= ADDR_SCRATCH) && (scr_off < 12'(4 * NUM_REGS));
  assign scr_idx = scr_off[IDX_W+1:2];

  always_comb begin
    rdata   = '0;
    reg_err = 1'b0;
    case (addr)
      ADDR_NAME0:    begin rdata = NAME0_VAL;    reg_err = we; end
      ADDR_NAME1:    begin rdata = NAME1_VAL;    reg_err = we; end
      ADDR_VERSION0: begin rdata = VERSION0_VAL; reg_err = we; end
      ADDR_VERSION1: begin rdata = VERSION1_VAL; reg_err = we; end
      ADDR_CTRL:     rdata = '0;
      ADDR_STATUS: begin
        rdata[STATUS_READY_BIT] = (state_q == ST_IDLE);
        rdata[STATUS_VALID_BIT] = valid_q;
        reg_err                 = we;
      end
      ADDR_INTR_STS: rdata[1:0] = sts_q;
      ADDR_INTR_EN:  rdata[1:0] = en_q;
      default: begin
        if (scr_hit) rdata = scratch_q[scr_idx];
        else         reg_err = 1'b1;
      end
    endcase
  end

  assign wr       = req & we & ~reg_err;
  assign scr_wr   = wr & scr_hit;
  assign ctrl_wr  = wr & (addr == ADDR_CTRL);
  // Zeroize takes priority over a command and over a completing BUSY.
  assign zeroize  = (ctrl_wr & wdata[CTRL_ZEROIZE_BIT]) | debugUnlock_or_scan_mode_switch;
  assign start    = ctrl_wr & (wdata[1:0] != 2'b00) & ~zeroize;
  assign w1c_mask = (wr && addr == ADDR_INTR_STS) ? wdata[1:0] : 2'b00;

`ifdef CRYPTO_STUB_BUSY_MODEL_EN
  localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zeroize)                                     cnt_d = '0;
    else if (state_q == ST_IDLE && start)            cnt_d = CNT_W'(BUSY_CYCLES - 1);
    else if (state_q == ST_BUSY && cnt_q != '0)      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign busy_done = (cnt_q == '0);
`else
  assign busy_done = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    set_mask = 2'b00;
    if (zeroize) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_BUSY;
            valid_d = 1'b0;
          end
        end
        ST_BUSY: begin
          if (start) set_mask[INTR_ERROR_BIT] = 1'b1;
          if (busy_done) begin
            state_d                     = ST_IDLE;
            valid_d                     = 1'b1;
            set_mask[INTR_NOTIF_BIT]    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Hardware set beats a same-cycle W1C.
  assign sts_d = (sts_q & ~w1c_mask) | set_mask;
  assign en_d  = (wr && addr == ADDR_INTR_EN) ? wdata[1:0] : en_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      valid_q      <= 1'b0;
      sts_q        <= 2'b00;
      en_q         <= 2'b00;
      notif_intr_q <= 1'b0;
      error_intr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      sts_q        <= sts_d;
      en_q         <= en_d;
      notif_intr_q <= sts_q[INTR_NOTIF_BIT] & en_q[INTR_NOTIF_BIT];
      error_intr_q <= sts_q[INTR_ERROR_BIT] & en_q[INTR_ERROR_BIT];
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_scratch
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                  scratch_q[gi] <= '0;
      else if (zeroize)                              scratch_q[gi] <= '0;
      else if (scr_wr && scr_idx == IDX_W'(gi))      scratch_q[gi] <= wdata;
    end
  end

  assign notif_intr = notif_intr_q;
  assign error_intr = error_intr_q;
  assign kv_read    = '0;
  assign kv_write   = '0;

  assign unused_inputs = ^{cptra_pwrgood, kv_rd_resp, kv_wr_resp, pcr_signing_data};

endmodule
